// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder (PHY side): oversamples MDC/MDIO on clk and turns
// management frames into local register read/write strobes.
//
// state | meaning
// PRE   | counting preamble ones; a 0 after a full preamble is ST bit 0
// ST    | expecting ST bit 1
// OP    | 2 opcode bits (10 read, 01 write)
// PHYAD | 5 PHY address bits
// REGAD | 5 register address bits; read strobe on the last one
// TA    | turnaround; checked on writes, driven 0 on matched reads
// DATA  | 16 data bits, shifted in (write) or driven out (read)
// REL   | matched read done; release MDIO on the next MDC fall
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR      = 5'd1,
    parameter int         PREAMBLE_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        busy,
    output logic        frame_err
);

    localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_BITS);

    typedef enum logic [2:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_REL
    } state_t;

    state_t      state_q, state_d;
    logic        mdc_m_q, mdc_m_d, mdc_s_q, mdc_s_d, mdc_p_q, mdc_p_d;
    logic        mdio_m_q, mdio_m_d, mdio_s_q, mdio_s_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] sh_q, sh_d;
    logic        is_rd_q, is_rd_d, match_q, match_d, rd_cap_q, rd_cap_d;
    logic        mdio_out_q, mdio_out_d, mdio_oe_q, mdio_oe_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic        reg_rd_q, reg_rd_d, reg_wr_q, reg_wr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        busy_q, busy_d, frame_err_q, frame_err_d;

    logic        rise, fall, drive;
    logic [15:0] sh_in;

    always_comb begin
        mdc_m_d     = mdc;
        mdc_s_d     = mdc_m_q;
        mdc_p_d     = mdc_s_q;
        mdio_m_d    = mdio_in;
        mdio_s_d    = mdio_m_q;
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        is_rd_d     = is_rd_q;
        match_d     = match_q;
        rd_cap_d    = reg_rd_q;
        mdio_out_d  = mdio_out_q;
        mdio_oe_d   = mdio_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        frame_err_d = 1'b0;

        rise  = mdc_s_q & ~mdc_p_q;
        fall  = ~mdc_s_q & mdc_p_q;
        drive = is_rd_q & match_q;
        sh_in = {sh_q[14:0], mdio_s_q};

        // Read data arrives one clk after the strobe; no MDC edge can be this close.
        if (rd_cap_q) begin
            sh_d = reg_rdata;
        end

        if (rise) begin
            case (state_q)
                S_PRE: begin
                    if (mdio_s_q) begin
                        if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q == PRE_MAX) begin
                        state_d   = S_ST;
                        pre_cnt_d = 6'd0;
                    end else begin
                        pre_cnt_d = 6'd0;
                    end
                end
                S_ST: begin
                    if (mdio_s_q) begin
                        state_d   = S_OP;
                        bit_cnt_d = 4'd1;
                    end else begin
                        state_d     = S_PRE;
                        frame_err_d = 1'b1;
                    end
                end
                S_OP: begin
                    sh_d = sh_in;
                    if (bit_cnt_q == 4'd0) begin
                        state_d   = S_PHYAD;
                        bit_cnt_d = 4'd4;
                        case (sh_in[1:0])
                            2'b10:   is_rd_d = 1'b1;
                            2'b01:   is_rd_d = 1'b0;
                            default: begin
                                state_d     = S_PRE;
                                frame_err_d = 1'b1;
                            end
                        endcase
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                S_PHYAD: begin
                    sh_d = sh_in;
                    if (bit_cnt_q == 4'd0) begin
                        match_d   = (sh_in[4:0] == PHY_ADDR);
                        state_d   = S_REGAD;
                        bit_cnt_d = 4'd4;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                S_REGAD: begin
                    sh_d = sh_in;
                    if (bit_cnt_q == 4'd0) begin
                        reg_addr_d = sh_in[4:0];
                        reg_rd_d   = is_rd_q & match_q;
                        state_d    = S_TA;
                        bit_cnt_d  = 4'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                S_TA: begin
                    // Write turnaround must read 1 then 0; bit_cnt_q[0] is exactly that.
                    if (!is_rd_q && (mdio_s_q != bit_cnt_q[0])) begin
                        state_d     = S_PRE;
                        frame_err_d = 1'b1;
                    end else if (bit_cnt_q == 4'd0) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 4'd15;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                S_DATA: begin
                    if (!is_rd_q) sh_d = sh_in;
                    if (bit_cnt_q == 4'd0) begin
                        if (!is_rd_q && match_q) begin
                            reg_wr_d    = 1'b1;
                            reg_wdata_d = sh_in;
                        end
                        state_d = drive ? S_REL : S_PRE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end

        if (fall) begin
            case (state_q)
                S_TA: begin
                    if (drive && bit_cnt_q == 4'd0) begin
                        mdio_oe_d  = 1'b1;
                        mdio_out_d = 1'b0;
                    end
                end
                S_DATA: begin
                    if (drive) begin
                        mdio_oe_d  = 1'b1;
                        mdio_out_d = sh_q[15];
                        sh_d       = {sh_q[14:0], 1'b0};
                    end
                end
                S_REL: begin
                    mdio_oe_d  = 1'b0;
                    mdio_out_d = 1'b0;
                    state_d    = S_PRE;
                end
                default: ;
            endcase
        end

        busy_d = (state_d != S_PRE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdc_m_q     <= 1'b0;
            mdc_s_q     <= 1'b0;
            mdc_p_q     <= 1'b0;
            mdio_m_q    <= 1'b0;
            mdio_s_q    <= 1'b0;
            state_q     <= S_PRE;
            pre_cnt_q   <= 6'd0;
            bit_cnt_q   <= 4'd0;
            sh_q        <= 16'd0;
            is_rd_q     <= 1'b0;
            match_q     <= 1'b0;
            rd_cap_q    <= 1'b0;
            mdio_out_q  <= 1'b0;
            mdio_oe_q   <= 1'b0;
            reg_addr_q  <= 5'd0;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= 16'd0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            mdc_m_q     <= mdc_m_d;
            mdc_s_q     <= mdc_s_d;
            mdc_p_q     <= mdc_p_d;
            mdio_m_q    <= mdio_m_d;
            mdio_s_q    <= mdio_s_d;
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            is_rd_q     <= is_rd_d;
            match_q     <= match_d;
            rd_cap_q    <= rd_cap_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oe_q   <= mdio_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mdio_out  = mdio_out_q;
    assign mdio_oe   = mdio_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_rd    = reg_rd_q;
    assign reg_wr    = reg_wr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: a behavioural MDIO master plays a table of
// frames; a registered local register model answers reads.
module tb_mdio_phy_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio_in = 1'b1;
    logic [15:0] reg_rdata = 16'h0;
    logic [15:0] rd_val = 16'h0;
    logic        mdio_out, mdio_oe, reg_rd, reg_wr, busy, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;

    mdio_phy_responder #(.PHY_ADDR(5'd1), .PREAMBLE_BITS(32)) dut (
        .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
        .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wr(reg_wr),
        .reg_wdata(reg_wdata), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Read data is valid only in the clk after reg_rd, as a registered register file would give it.
    always @(posedge clk) reg_rdata <= reg_rd ? rd_val : 16'hDEAD;

    int          n_chk = 0, n_err = 0;
    int          wr_n, rd_n, err_n, both_n;
    logic [4:0]  wr_a, rd_a;
    logic [15:0] wr_d;
    logic        oe_seen, busy_seen;

    always @(negedge clk) begin
        if (reg_wr) begin wr_n++; wr_a = reg_addr; wr_d = reg_wdata; end
        if (reg_rd) begin rd_n++; rd_a = reg_addr; end
        if (reg_rd && reg_wr) both_n++;
        if (frame_err) err_n++;
        if (mdio_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic clr_mon();
        wr_n = 0; rd_n = 0; err_n = 0; both_n = 0;
        oe_seen = 1'b0; busy_seen = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One MDC period: fall, settle, sample bus just before rise, rise.
    task automatic mac_bit(input logic b, input logic drv, output logic smp, output logic oe_smp);
        mdc = 1'b0;
        mdio_in = drv ? b : 1'b1;
        #40;
        if (!drv) mdio_in = mdio_oe ? mdio_out : 1'b1;
        #39;
        oe_smp = mdio_oe;
        smp = mdio_oe ? mdio_out : 1'b1;
        #1 mdc = 1'b1;
        #80;
    endtask

    task automatic mac_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] wd,
                             output logic [15:0] rd, output logic ta2, output int oe_n);
        logic s, o;
        oe_n = 0; rd = 16'h0; ta2 = 1'b0;
        for (int k = 0; k < npre; k++) mac_bit(1'b1, 1'b1, s, o);
        mac_bit(1'b0, 1'b1, s, o);
        mac_bit(1'b1, 1'b1, s, o);
        for (int k = 1; k >= 0; k--) mac_bit(op[k], 1'b1, s, o);
        for (int k = 4; k >= 0; k--) mac_bit(phy[k], 1'b1, s, o);
        for (int k = 4; k >= 0; k--) mac_bit(rg[k], 1'b1, s, o);
        if (op == 2'b10) begin
            for (int k = 0; k < 2; k++) begin
                mac_bit(1'b1, 1'b0, s, o);
                if (o) oe_n++;
                if (k == 1) ta2 = s;
            end
            for (int k = 15; k >= 0; k--) begin
                mac_bit(1'b1, 1'b0, s, o);
                if (o) oe_n++;
                rd[k] = s;
            end
        end else begin
            for (int k = 1; k >= 0; k--) mac_bit(ta[k], 1'b1, s, o);
            for (int k = 15; k >= 0; k--) mac_bit(wd[k], 1'b1, s, o);
        end
        mdc = 1'b0;
        mdio_in = 1'b1;
        #80;
    endtask

    typedef struct {
        int          npre;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [1:0]  ta;
        logic [15:0] wd;
        logic [15:0] rv;
        int          e_wr;
        int          e_rd;
        int          e_err;
        logic        e_busy;
        int          e_oe;
        logic [15:0] e_bus;
        logic        e_ta2;
    } vec_t;

    vec_t        v[12];
    logic [15:0] got;
    logic        ta2, s, o;
    int          oe_n;

    initial begin
        //        npre op     phy    rg      ta     wd        rv        wr rd er busy  oe  bus       ta2
        v[0]  = '{32, 2'b01, 5'd1, 5'd4,  2'b10, 16'hA5C3, 16'h0000, 1, 0, 0, 1'b1, 0,  16'h0000, 1'b0};
        v[1]  = '{32, 2'b10, 5'd1, 5'd2,  2'b00, 16'h0000, 16'h1234, 0, 1, 0, 1'b1, 17, 16'h1234, 1'b0};
        v[2]  = '{32, 2'b10, 5'd3, 5'd2,  2'b00, 16'h0000, 16'h1234, 0, 0, 0, 1'b1, 0,  16'hFFFF, 1'b1};
        v[3]  = '{32, 2'b01, 5'd3, 5'd5,  2'b10, 16'h5A5A, 16'h0000, 0, 0, 0, 1'b1, 0,  16'h0000, 1'b0};
        v[4]  = '{32, 2'b10, 5'd1, 5'd7,  2'b00, 16'h0000, 16'hBEEF, 0, 1, 0, 1'b1, 17, 16'hBEEF, 1'b0};
        v[5]  = '{31, 2'b01, 5'd1, 5'd4,  2'b10, 16'h1111, 16'h0000, 0, 0, 0, 1'b0, 0,  16'h0000, 1'b0};
        v[6]  = '{32, 2'b11, 5'd1, 5'd4,  2'b10, 16'h0000, 16'h0000, 0, 0, 1, 1'b1, 0,  16'h0000, 1'b0};
        v[7]  = '{32, 2'b01, 5'd1, 5'd9,  2'b10, 16'h0F0F, 16'h0000, 1, 0, 0, 1'b1, 0,  16'h0000, 1'b0};
        v[8]  = '{32, 2'b01, 5'd1, 5'd3,  2'b11, 16'h1234, 16'h0000, 0, 0, 1, 1'b1, 0,  16'h0000, 1'b0};
        v[9]  = '{32, 2'b10, 5'd1, 5'd1,  2'b00, 16'h0000, 16'hC3A5, 0, 1, 0, 1'b1, 17, 16'hC3A5, 1'b0};
        v[10] = '{32, 2'b01, 5'd1, 5'd31, 2'b10, 16'hFFFF, 16'h0000, 1, 0, 0, 1'b1, 0,  16'h0000, 1'b0};
        v[11] = '{32, 2'b10, 5'd1, 5'd0,  2'b00, 16'h0000, 16'h0000, 0, 1, 0, 1'b1, 17, 16'h0000, 1'b0};

        clr_mon();
        #22;
        chk("reset outputs", {27'h0, mdio_out, mdio_oe, reg_rd, reg_wr, frame_err},  32'h0);
        chk("reset regs", {10'h0, busy, reg_addr, reg_wdata}, 32'h0);
        #30 reset = 1'b0;
        #50;

        for (int i = 0; i < 12; i++) begin
            rd_val = v[i].rv;
            clr_mon();
            mac_frame(v[i].npre, v[i].op, v[i].phy, v[i].rg, v[i].ta, v[i].wd, got, ta2, oe_n);
            #200;
            chk($sformatf("v%0d wr_count", i), 32'(wr_n), 32'(v[i].e_wr));
            chk($sformatf("v%0d rd_count", i), 32'(rd_n), 32'(v[i].e_rd));
            chk($sformatf("v%0d err_count", i), 32'(err_n), 32'(v[i].e_err));
            chk($sformatf("v%0d rd_wr_same_clk", i), 32'(both_n), 32'h0);
            chk($sformatf("v%0d busy_seen", i), 32'(busy_seen), 32'(v[i].e_busy));
            chk($sformatf("v%0d oe_seen", i), 32'(oe_seen), 32'(v[i].e_oe != 0));
            chk($sformatf("v%0d busy_after", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d oe_after", i), 32'(mdio_oe), 32'h0);
            if (v[i].e_wr != 0) begin
                chk($sformatf("v%0d wr_addr", i), 32'(wr_a), 32'(v[i].rg));
                chk($sformatf("v%0d wr_data", i), 32'(wr_d), 32'(v[i].wd));
            end
            if (v[i].e_rd != 0) chk($sformatf("v%0d rd_addr", i), 32'(rd_a), 32'(v[i].rg));
            if (v[i].op == 2'b10) begin
                chk($sformatf("v%0d oe_periods", i), 32'(oe_n), 32'(v[i].e_oe));
                chk($sformatf("v%0d read_bus", i), 32'(got), 32'(v[i].e_bus));
                chk($sformatf("v%0d ta2_bit", i), 32'(ta2), 32'(v[i].e_ta2));
            end
        end

        // Reset during read data bit 8.
        rd_val = 16'h5555;
        for (int k = 0; k < 32; k++) mac_bit(1'b1, 1'b1, s, o);
        mac_bit(1'b0, 1'b1, s, o);
        mac_bit(1'b1, 1'b1, s, o);
        mac_bit(1'b1, 1'b1, s, o);
        mac_bit(1'b0, 1'b1, s, o);
        for (int k = 4; k >= 0; k--) mac_bit(k == 0, 1'b1, s, o);
        for (int k = 4; k >= 0; k--) mac_bit(k == 1, 1'b1, s, o);
        for (int k = 0; k < 9; k++) mac_bit(1'b1, 1'b0, s, o);
        mdc = 1'b0;
        mdio_in = 1'b1;
        #40;
        chk("rst_mid oe_before", 32'(mdio_oe), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid oe_async", 32'(mdio_oe), 32'h0);
        chk("rst_mid outputs", {10'h0, busy, reg_addr, reg_wdata}, 32'h0);
        #39 mdc = 1'b1;
        #80;
        #100 reset = 1'b0;
        clr_mon();
        for (int k = 0; k < 8; k++) mac_bit(1'b1, 1'b0, s, o);
        mdc = 1'b0;
        #200;
        chk("rst_mid partial_ignored", {28'h0, 4'(wr_n + rd_n + err_n)}, 32'h0);
        chk("rst_mid oe_quiet", 32'(oe_seen), 32'h0);

        rd_val = 16'h6789;
        clr_mon();
        mac_frame(32, 2'b10, 5'd1, 5'd6, 2'b00, 16'h0, got, ta2, oe_n);
        #200;
        chk("post_rst rd_count", 32'(rd_n), 32'h1);
        chk("post_rst rd_addr", 32'(rd_a), 32'd6);
        chk("post_rst read_bus", 32'(got), 32'h6789);
        chk("post_rst oe_periods", 32'(oe_n), 32'd17);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
